// File: rtl/rca_writeback_source_if.sv
// Writeback handshake between the RCA result buffer and the
// register-file stage: id/done/rd from the producer, ack back.
interface rca_writeback_interface #(
  parameter int NUM_WRITE_PORTS = 2,
  parameter int XLEN            = 32,
  parameter int ID_W            = 8
);
  logic [ID_W-1:0]                      id;
  logic                                 done;
  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] rd;
  logic                                 ack;

  modport unit (
    output id,
    output done,
    output rd,
    input  ack
  );

  modport wb (
    input  id,
    input  done,
    input  rd,
    output ack
  );
endinterface

// File: rtl/rca_writeback_source.sv
// RCA writeback source: in-order FIFO of completed RCA results.
// Ports: result_* push side, rca_wb head/ack, gc_flush, occupancy.
module rca_writeback_source #(
  parameter int NUM_WRITE_PORTS = 2,
  parameter int DEPTH           = 4,
  parameter int XLEN            = 32,
  parameter int ID_W            = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 result_valid,
  output logic                                 result_ready,
  input  logic [ID_W-1:0]                      result_id,
  input  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] result_data,
  input  logic [NUM_WRITE_PORTS-1:0][4:0]      result_rd_addr,
  input  logic                                 gc_flush,
  rca_writeback_interface.unit                 rca_wb,
  output logic [NUM_WRITE_PORTS-1:0][4:0]      rca_retired_rd_addrs,
  output logic [$clog2(DEPTH+1)-1:0]           occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ID_W-1:0]                      id_mem   [DEPTH];
  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] data_mem [DEPTH];
  logic [NUM_WRITE_PORTS-1:0][4:0]      addr_mem [DEPTH];

  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;

  logic done;
  logic push;
  logic pop;

  // Ready looks only at the registered count, so a full
  // buffer refuses a push even when a pop frees a slot.
  assign result_ready = (count_q < FULL);
  assign done         = (count_q != '0);
  assign push         = result_valid & result_ready & ~gc_flush;
  assign pop          = rca_wb.ack & done & ~gc_flush;

  // Head fields read as zero when empty, since RAM is unreset.
  assign rca_wb.done = done;
  assign rca_wb.id   = done ? id_mem[rptr_q] : '0;
  assign rca_wb.rd   = done ? data_mem[rptr_q] : '0;

  assign rca_retired_rd_addrs = done ? addr_mem[rptr_q] : '0;
  assign occupancy            = count_q;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (gc_flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      id_mem[wptr_q]   <= result_id;
      data_mem[wptr_q] <= result_data;
      addr_mem[wptr_q] <= result_rd_addr;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow : assert property (
    @(posedge clk) disable iff (rst)
    !(push && count_q == FULL));

  a_head_stable : assert property (
    @(posedge clk) disable iff (rst)
    (done && !rca_wb.ack && !gc_flush) |=>
      ($stable(rca_wb.id) && $stable(rca_wb.rd) &&
       $stable(rca_retired_rd_addrs)));
`endif

endmodule

// File: tb/tb_rca_writeback_source.sv
// Directed bench for rca_writeback_source: push, fill, drain,
// wrap, simultaneous push/pop, flush and mid-run reset.
module tb_rca_writeback_source;
  localparam int NW = 2;
  localparam int XL = 32;
  localparam int IW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              result_valid;
  logic              result_ready;
  logic [IW-1:0]     result_id;
  logic [NW-1:0][XL-1:0] result_data;
  logic [NW-1:0][4:0]    result_rd_addr;
  logic              gc_flush;
  logic [NW-1:0][4:0]    addrs;
  logic [2:0]        occupancy;

  int checks = 0;
  int failures = 0;

  rca_writeback_interface #(
    .NUM_WRITE_PORTS(NW), .XLEN(XL), .ID_W(IW)
  ) wb ();

  rca_writeback_source #(
    .NUM_WRITE_PORTS(NW), .DEPTH(4), .XLEN(XL), .ID_W(IW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .result_valid         (result_valid),
    .result_ready         (result_ready),
    .result_id            (result_id),
    .result_data          (result_data),
    .result_rd_addr       (result_rd_addr),
    .gc_flush             (gc_flush),
    .rca_wb               (wb),
    .rca_retired_rd_addrs (addrs),
    .occupancy            (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entry pattern: data {id*16+1, id*16+2}, rd {id&31, (id+8)&31}.
  task automatic drive(input logic [IW-1:0] id);
    result_valid      = 1'b1;
    result_id         = id;
    result_data[0]    = XL'(id) * 16 + 1;
    result_data[1]    = XL'(id) * 16 + 2;
    result_rd_addr[0] = id[4:0];
    result_rd_addr[1] = id[4:0] + 5'd8;
  endtask

  task automatic head(input string tag, input logic [IW-1:0] id);
    logic [4:0] a1;
    a1 = id[4:0] + 5'd8;
    check({tag, ".done"}, 64'(wb.done), 64'd1);
    check({tag, ".id"}, 64'(wb.id), 64'(id));
    check({tag, ".d0"}, 64'(wb.rd[0]), 64'(id) * 16 + 1);
    check({tag, ".d1"}, 64'(wb.rd[1]), 64'(id) * 16 + 2);
    check({tag, ".a0"}, 64'(addrs[0]), 64'(id[4:0]));
    check({tag, ".a1"}, 64'(addrs[1]), 64'(a1));
  endtask

  initial begin
    rst = 1'b1; result_valid = 1'b0; result_id = '0;
    result_data = '0; result_rd_addr = '0;
    gc_flush = 1'b0; wb.ack = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst.done", 64'(wb.done), 64'd0);
    check("rst.ready", 64'(result_ready), 64'd1);
    check("rst.occ", 64'(occupancy), 64'd0);
    check("rst.addrs", 64'(addrs), 64'd0);

    // Single result with spec values, ack held high throughout.
    wb.ack = 1'b1;
    step();
    check("ackempty.occ", 64'(occupancy), 64'd0);
    result_valid = 1'b1; result_id = 8'd3;
    result_data[0] = 32'h11; result_data[1] = 32'h22;
    result_rd_addr[0] = 5'd5; result_rd_addr[1] = 5'd6;
    check("single.pre", 64'(wb.done), 64'd0);
    step();
    result_valid = 1'b0;
    check("single.done", 64'(wb.done), 64'd1);
    check("single.id", 64'(wb.id), 64'd3);
    check("single.d0", 64'(wb.rd[0]), 64'h11);
    check("single.d1", 64'(wb.rd[1]), 64'h22);
    check("single.a0", 64'(addrs[0]), 64'd5);
    check("single.a1", 64'(addrs[1]), 64'd6);
    step();
    check("single.post", 64'(wb.done), 64'd0);

    // Fill to full with ack low, then hold a fifth valid.
    wb.ack = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(IW'(i));
      step();
      head("fill", 8'd1);
    end
    check("full.ready", 64'(result_ready), 64'd0);
    check("full.occ", 64'(occupancy), 64'd4);
    drive(8'd5);
    step(); step();
    check("over.occ", 64'(occupancy), 64'd4);
    head("over", 8'd1);

    // Drain one per cycle.
    result_valid = 1'b0;
    wb.ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      head("drain", IW'(i));
      step();
    end
    check("drain.done", 64'(wb.done), 64'd0);
    check("drain.occ", 64'(occupancy), 64'd0);

    // Refill after pointer wrap and drain again.
    wb.ack = 1'b0;
    for (int i = 9; i <= 12; i++) begin
      drive(IW'(i));
      step();
    end
    result_valid = 1'b0;
    check("refill.occ", 64'(occupancy), 64'd4);
    wb.ack = 1'b1;
    for (int i = 9; i <= 12; i++) begin
      head("redrain", IW'(i));
      step();
    end
    check("redrain.done", 64'(wb.done), 64'd0);

    // Simultaneous push and pop at occupancy 2.
    wb.ack = 1'b0;
    drive(8'd20); step();
    drive(8'd21); step();
    check("sim.occ0", 64'(occupancy), 64'd2);
    drive(8'd7); wb.ack = 1'b1;
    step();
    result_valid = 1'b0;
    check("sim.occ1", 64'(occupancy), 64'd2);
    head("sim.h1", 8'd21);
    step();
    head("sim.h2", 8'd7);
    step();
    check("sim.done", 64'(wb.done), 64'd0);

    // Flush with push and ack in the same cycle.
    wb.ack = 1'b0;
    drive(8'd30); step();
    drive(8'd31); step();
    drive(8'd32); step();
    check("fl.occ0", 64'(occupancy), 64'd3);
    drive(8'd33); wb.ack = 1'b1; gc_flush = 1'b1;
    step();
    gc_flush = 1'b0; result_valid = 1'b0;
    check("fl.occ", 64'(occupancy), 64'd0);
    check("fl.done", 64'(wb.done), 64'd0);
    check("fl.ready", 64'(result_ready), 64'd1);
    step();
    check("fl.done2", 64'(wb.done), 64'd0);
    wb.ack = 1'b0;
    drive(8'd34); step();
    result_valid = 1'b0;
    head("fl.next", 8'd34);
    check("fl.occ2", 64'(occupancy), 64'd1);
    wb.ack = 1'b1; step(); wb.ack = 1'b0;

    // Reset mid-operation.
    drive(8'd40); step();
    drive(8'd41); step();
    result_valid = 1'b0;
    check("mr.occ0", 64'(occupancy), 64'd2);
    rst = 1'b1; step(); rst = 1'b0;
    check("mr.done", 64'(wb.done), 64'd0);
    check("mr.occ", 64'(occupancy), 64'd0);
    check("mr.ready", 64'(result_ready), 64'd1);
    check("mr.addrs", 64'(addrs), 64'd0);
    wb.ack = 1'b1; step(); step();
    check("mr.done2", 64'(wb.done), 64'd0);
    wb.ack = 1'b0;
    drive(8'd42); step();
    result_valid = 1'b0;
    head("mr.next", 8'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rca_writeback_source.md
Name: rca_writeback_source

Overview:
Producer end of the RCA writeback path.
- Accepts completed RCA instruction results: one ID plus NUM_WRITE_PORTS data words and destination register addresses per instruction.
- Buffers them in an in-order FIFO.
- Presents the head entry to the register-file/writeback stage through rca_writeback_interface (drives id, done, rd; consumes ack).
- Drives the matching destination addresses on rca_retired_rd_addrs.

Parameters:
NUM_WRITE_PORTS, 2, result words and destination registers per RCA instruction; must match rca_writeback_interface.
DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
result_valid  input  1  RCA grid presents a completed instruction
result_ready  output  1  buffer can accept; equals (count < DEPTH)
result_id  input  id_t  instruction ID of the presented result
result_data  input  [NUM_WRITE_PORTS][XLEN]  result words
result_rd_addr  input  [NUM_WRITE_PORTS][5]  destination registers; 0 means the port does not write
gc_flush  input  1  discard all buffered results
rca_wb  interface  rca_writeback_interface.unit  drives id, done, rd[NUM_WRITE_PORTS]; receives ack
rca_retired_rd_addrs  output  [NUM_WRITE_PORTS][5]  destination addresses of the head entry
occupancy  output  [$clog2(DEPTH+1)]  current entry count

Behaviour:
Reset:
- At the rst edge: read pointer, write pointer and count cleared to 0.
- After reset: done=0, result_ready=1, occupancy=0, rca_retired_rd_addrs=0.
- Storage RAM is not reset.
- rst wins over every other input in the same cycle.

Push:
- A push occurs when result_valid & result_ready.
- The entry {id, data, rd_addr} is written at the write pointer; the write pointer increments modulo DEPTH.
- result_ready is derived from the registered count only. A push is refused when count==DEPTH even if a pop happens in the same cycle.

Pop:
- done = (count != 0).
- rca_wb.id, rca_wb.rd[i] and rca_retired_rd_addrs[i] come from the head entry. They stay stable while done=1 and ack=0.
- A pop occurs when rca_wb.ack & done; the read pointer increments modulo DEPTH.
- ack while done=0 is ignored: no pointer or count change.

Latency:
- A result pushed into an empty buffer shows done=1 in the following cycle. There is no bypass.
- Back-to-back pops give one retirement per cycle.

Count update:
- push only: +1.
- pop only: -1.
- push and pop together: unchanged, both pointers advance.
- Count never wraps; pointers wrap modulo DEPTH.

Flush:
- On gc_flush=1, the next edge sets pointers and count to 0. done=0 in the following cycle.
- A push or ack in the flush cycle is discarded.
- result_ready stays computed from count, so the upstream handshake is still legal during flush.

Ordering:
- Strict FIFO; IDs retire in acceptance order.
- The block does no ID checking. LVT update gating is the consumer's job.

Zero destinations:
- Entries with rd_addr=0 are buffered and retired normally.
- The consumer suppresses the write; this block does not filter.

Assertions (simulation only):
- No push while count==DEPTH.
- Head outputs stable while done & ~ack.

Test Plan:
- Single result: push id=3, data={0x11,0x22}, rd={5,6} into empty buffer, ack held 1 -> done=1 exactly one cycle after the push, id=3, rd={0x11,0x22}, addrs={5,6}; done=0 the cycle after the pop.
- Fill: 4 pushes with ids 1..4, ack=0 -> result_ready=0 and occupancy=4 after the 4th push; 5th valid held and not accepted; done held with head id=1 throughout.
- Stall then drain: from full, ack=1 for 4 cycles -> ids retire 1,2,3,4 on consecutive cycles; done=0 afterwards; pointers wrap with no data corruption on a subsequent 4-entry refill.
- Simultaneous: occupancy=2, push id=7 and ack on the same cycle -> occupancy stays 2; head advances; id=7 retires last.
- Flush: occupancy=3 with push and ack asserted alongside gc_flush -> next cycle occupancy=0, done=0; the pushed id never appears on rca_wb.
- Reset mid-operation: occupancy=2, done=1, rst pulsed one cycle -> done=0, occupancy=0, result_ready=1 the cycle after reset; earlier entries never retire.
